fire_alert_fusion: RTL and testbench

Parametrised multi-sensor fire-alert fusion block, the next-generation replacement for the two-input fire alert logic between the sensor front ends (ESP32 FFT flag, Pi camera flag, future sensors) and the alert output to the ESP32. It synchronises and debounces each sensor flag independently and applies a k-of-N vote over the enabled channels. A confirm/hold state machine then drives a single registered alert. It also exposes per-channel debug status and a saturating alert-event count for LEDs and telemetry.

---
 rtl/fire_alert_fusion.sv | 163 ++++++++++++++++
 tb/tb_fire_alert_fusion.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fire_alert_fusion.sv
// k-of-N fire alert fusion: 2-flop sync + per-channel debounce, vote, confirm/hold FSM.
// Alert rises 3+DEBOUNCE+CONFIRM edges after a stable input; no backpressure. Option: FIRE_ALERT_STICKY_EN.
module fire_alert_fusion #(
   parameter int NUM_CH          = 4,
   parameter int VOTE_THRESH     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CONFIRM_CYCLES  = 100000,
   parameter int HOLD_CYCLES     = 500000,
   parameter int CNT_W           = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] flag_in,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic              ack,
   output logic              alert_out,
   output logic [NUM_CH-1:0] ch_valid,
   output logic [1:0]        alert_state,
   output logic [CNT_W-1:0]  alert_count
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TMAX = (CONFIRM_CYCLES > HOLD_CYCLES) ? CONFIRM_CYCLES : HOLD_CYCLES;
   localparam int TM_W = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int VW   = $clog2(NUM_CH + 1);

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TM_W-1:0] CONF_LAST = TM_W'(CONFIRM_CYCLES - 1);
   localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYCLES - 1);
   localparam logic [VW-1:0]   THRESH    = VW'(VOTE_THRESH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      ALERT = 2'd2
   } state_t;

   logic [NUM_CH-1:0] s1_q, s2_q;
   logic [NUM_CH-1:0] valid_q, valid_d;
   logic [DB_W-1:0]   db_cnt_q [NUM_CH];
   logic [DB_W-1:0]   db_cnt_d [NUM_CH];

   state_t            state_q, state_d;
   logic [TM_W-1:0]   timer_q, timer_d;
   logic              alert_q, alert_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [NUM_CH-1:0] masked;
   logic [VW-1:0]     vote;
   logic              vote_met;

   // Counter only runs while the synchronised input disagrees with the debounced value.
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < NUM_CH; i++) begin
         db_cnt_d[i] = '0;
         if (s2_q[i] != valid_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               valid_d[i] = ~valid_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      masked = valid_q & ch_enable;
      vote   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         vote = vote + VW'(masked[i]);
      end
      vote_met = (vote >= THRESH);
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      alert_d = alert_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (vote_met) begin
               state_d = ARM;
               timer_d = '0;
            end
         end
         ARM: begin
            if (!vote_met) begin
               state_d = IDLE;
            end else if (timer_q == CONF_LAST) begin
               state_d = ALERT;
               alert_d = 1'b1;
               timer_d = '0;
               if (count_q != '1) begin
                  count_d = count_q + 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ALERT: begin
            if (vote_met) begin
               timer_d = '0;
            end else if (timer_q == HOLD_LAST) begin
`ifdef FIRE_ALERT_STICKY_EN
               // Timer parks at HOLD_LAST; only an operator ack releases the alert.
               if (ack) begin
                  state_d = IDLE;
                  alert_d = 1'b0;
               end
`else
               state_d = IDLE;
               alert_d = 1'b0;
`endif
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            alert_d = 1'b0;
         end
      endcase
   end

`ifndef FIRE_ALERT_STICKY_EN
   logic unused_ack;
   assign unused_ack = ack;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         valid_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            db_cnt_q[i] <= '0;
         end
         state_q <= IDLE;
         timer_q <= '0;
         alert_q <= 1'b0;
         count_q <= '0;
      end else begin
         s1_q    <= flag_in;
         s2_q    <= s1_q;
         valid_q <= valid_d;
         for (int i = 0; i < NUM_CH; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
         state_q <= state_d;
         timer_q <= timer_d;
         alert_q <= alert_d;
         count_q <= count_d;
      end
   end

   assign alert_out   = alert_q;
   assign ch_valid    = valid_q;
   assign alert_state = state_q;
   assign alert_count = count_q;

endmodule

// File: tb/tb_fire_alert_fusion.sv
// Directed bench for fire_alert_fusion with DEBOUNCE=4, CONFIRM=3, HOLD=5.
// Inputs change #1 after a rising edge; outputs are sampled there as well.
module tb_fire_alert_fusion;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] flag_in;
   logic [3:0] ch_enable;
   logic       ack;
   logic       alert_out;
   logic [3:0] ch_valid;
   logic [1:0] alert_state;
   logic [7:0] alert_count;

   int total = 0;
   int bad   = 0;

   fire_alert_fusion #(
      .NUM_CH(4), .VOTE_THRESH(2), .DEBOUNCE_CYCLES(4),
      .CONFIRM_CYCLES(3), .HOLD_CYCLES(5), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .flag_in(flag_in), .ch_enable(ch_enable),
      .ack(ack), .alert_out(alert_out), .ch_valid(ch_valid),
      .alert_state(alert_state), .alert_count(alert_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      flag_in   = 4'b1111;
      ch_enable = 4'b1111;
      ack       = 1'b0;

      // reset with all flags high, then end-to-end latency
      step(2);
      chk("rst_alert", alert_out, 0);
      chk("rst_valid", ch_valid, 0);
      chk("rst_state", alert_state, 0);
      chk("rst_count", alert_count, 0);
      reset = 1'b0;
      step(5);
      chk("valid_e5", ch_valid, 4'b0000);
      step(1);
      chk("valid_e6", ch_valid, 4'b1111);
      step(3);
      chk("state_e9", alert_state, 1);
      chk("alert_e9", alert_out, 0);
      step(1);
      chk("alert_e10", alert_out, 1);
      chk("count_e10", alert_count, 1);
      chk("state_e10", alert_state, 2);

      // reset mid-alert overrides ack
      reset = 1'b1;
      ack   = 1'b1;
      step(1);
      chk("midrst_alert", alert_out, 0);
      chk("midrst_count", alert_count, 0);
      chk("midrst_state", alert_state, 0);
      step(1);
      reset = 1'b0;
      ack   = 1'b0;

      // glitch reject: 3-cycle pulse vanishes, 4-cycle pulse passes
      flag_in = 4'b0000;
      do_reset();
      step(6);
      flag_in = 4'b0001;
      step(3);
      flag_in = 4'b0000;
      step(8);
      chk("glitch3_valid", ch_valid, 0);
      chk("glitch3_state", alert_state, 0);
      flag_in = 4'b0001;
      step(4);
      flag_in = 4'b0000;
      step(1);
      chk("pulse4_e5", ch_valid, 4'b0000);
      step(1);
      chk("pulse4_e6", ch_valid, 4'b0001);
      step(3);
      chk("pulse4_e9", ch_valid, 4'b0001);
      step(1);
      chk("pulse4_e10", ch_valid, 4'b0000);
      chk("pulse4_state", alert_state, 0);

      // vote threshold
      do_reset();
      flag_in = 4'b0010;
      step(8);
      chk("one_ch_valid", ch_valid, 4'b0010);
      chk("one_ch_alert", alert_out, 0);
      chk("one_ch_state", alert_state, 0);
      flag_in = 4'b0110;
      step(9);
      chk("two_ch_e9", alert_out, 0);
      step(1);
      chk("two_ch_e10", alert_out, 1);

      do_reset();
      flag_in = 4'b0110;
      step(7);
      chk("en_arm", alert_state, 1);
      ch_enable = 4'b1011;
      step(1);
      chk("en_drop_state", alert_state, 0);
      step(5);
      chk("en_drop_alert", alert_out, 0);
      chk("en_drop_count", alert_count, 0);
      ch_enable = 4'b1111;

      // confirm abort after two vote_met edges
      do_reset();
      flag_in = 4'b0011;
      step(7);
      chk("abort_arm1", alert_state, 1);
      step(1);
      chk("abort_arm2", alert_state, 1);
      ch_enable = 4'b1110;
      step(1);
      chk("abort_idle", alert_state, 0);
      chk("abort_count", alert_count, 0);
      step(3);
      chk("abort_alert", alert_out, 0);
      ch_enable = 4'b1111;

      // hold after both flags drop
      do_reset();
      flag_in = 4'b0011;
      step(10);
      chk("hold_alert_on", alert_out, 1);
      flag_in = 4'b0000;
      step(10);
      chk("hold_e10", alert_out, 1);
      step(1);
`ifdef FIRE_ALERT_STICKY_EN
      chk("sticky_e11", alert_out, 1);
      step(3);
      chk("sticky_e14", alert_state, 2);
`else
      chk("hold_e11", alert_out, 0);
      chk("hold_e11_state", alert_state, 0);
      chk("hold_count", alert_count, 1);
`endif

      // one-cycle vote recovery restarts the hold; stray ack has no early effect
      do_reset();
      flag_in = 4'b0011;
      step(10);
      ch_enable = 4'b0000;
      step(3);
      ch_enable = 4'b1111;
      step(1);
      ch_enable = 4'b0000;
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      step(3);
      chk("restart_low4", alert_out, 1);
      step(1);
`ifdef FIRE_ALERT_STICKY_EN
      chk("restart_low5_sticky", alert_out, 1);
      ch_enable = 4'b1111;
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      chk("ack_vote_met", alert_out, 1);
      ch_enable = 4'b0000;
      step(3);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      chk("ack_early", alert_out, 1);
      step(2);
      chk("ack_wait_state", alert_state, 2);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      chk("ack_clear", alert_out, 0);
      chk("ack_clear_state", alert_state, 0);
`else
      chk("restart_low5", alert_out, 0);
      chk("restart_state", alert_state, 0);
`endif

      // alert counter saturation
      do_reset();
      flag_in   = 4'b1111;
      ch_enable = 4'b1111;
      step(10);
      for (int n = 2; n <= 256; n++) begin
         ch_enable = 4'b0000;
`ifdef FIRE_ALERT_STICKY_EN
         step(4);
         ack = 1'b1;
         step(1);
         ack = 1'b0;
`else
         step(5);
`endif
         if (n == 2) chk("sat_cleared", alert_state, 0);
         ch_enable = 4'b1111;
         step(4);
         if (n == 2)   chk("sat_n2", alert_count, 2);
         if (n == 255) chk("sat_n255", alert_count, 255);
         if (n == 256) begin
            chk("sat_n256", alert_count, 255);
            chk("sat_alert", alert_out, 1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
